// File: rtl/systolic_pkg.sv
// Shared types and helpers for the systolic array feeder.
// State encodings for the optional OS sequence exist only with SYSTOLIC_FEEDER_OS_EN.
package systolic_pkg;

    typedef enum logic [3:0] {
        S_IDLE     = 4'd0,
        S_WLOAD    = 4'd1,
        S_WSETTLE  = 4'd2,
        S_STREAM   = 4'd3,
        S_DRAIN    = 4'd4,
        S_DONE     = 4'd5
`ifdef SYSTOLIC_FEEDER_OS_EN
        ,
        S_OS_CLEAR = 4'd6,
        S_OS_FEED  = 4'd7,
        S_OS_FLUSH = 4'd8,
        S_OS_DRAIN = 4'd9
`endif
    } feeder_state_e;

    // Input register + per-lane skew + SW PE rows + output de-skew.
    function automatic int LAT_CYCLES(input int sw);
        return 2 * sw;
    endfunction

    function automatic int lane_lsb(input int lane, input int width);
        return lane * width;
    endfunction

endpackage

// File: rtl/valid_pipe.sv
// Fixed-depth {valid, last} delay line that tracks rows through the array.
// DEPTH must be at least 2.
module valid_pipe #(
    parameter int DEPTH = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic valid_i,
    input  logic last_i,
    output logic valid_o,
    output logic last_o
);

    logic [DEPTH-1:0] valid_q;
    logic [DEPTH-1:0] last_q;

    // NOTE: this line is control state, not data storage, so it is reset; a stale
    // valid bit after reset would emit a phantom result row.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            last_q  <= '0;
        end else begin
            // NOTE: non-blocking so every stage shifts from the pre-edge value.
            valid_q <= {valid_q[DEPTH-2:0], valid_i};
            last_q  <= {last_q[DEPTH-2:0], last_i};
        end
    end

    assign valid_o = valid_q[DEPTH-1];
    assign last_o  = last_q[DEPTH-1];

endmodule

// File: rtl/systolic_feeder.sv
// Sequencer feeding weight/activation rows into the systolic array and aligning
// out_valid/out_last with sum_out. OS mode is built only with SYSTOLIC_FEEDER_OS_EN.
module systolic_feeder
    import systolic_pkg::*;
#(
    parameter int DATA_WIDTH     = 16,
    parameter int SUM_WIDTH      = 16,
    parameter int SYSTOLIC_WIDTH = 4,
    parameter int ROW_CNT_W      = 8
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 start,
    input  logic                                 os_mode,
    input  logic [ROW_CNT_W-1:0]                 num_rows,
    input  logic                                 w_valid,
    output logic                                 w_ready,
    input  logic [SYSTOLIC_WIDTH*DATA_WIDTH-1:0] w_data,
    input  logic                                 a_valid,
    output logic                                 a_ready,
    input  logic [SYSTOLIC_WIDTH*DATA_WIDTH-1:0] a_data,
    output logic [SYSTOLIC_WIDTH*DATA_WIDTH-1:0] a_in_raw,
    output logic [SYSTOLIC_WIDTH*DATA_WIDTH-1:0] b_in_raw,
    output logic [SYSTOLIC_WIDTH*SUM_WIDTH-1:0]  sum_in_raw,
    output logic                                 mode,
    output logic                                 state,
    output logic                                 enable,
    output logic                                 busy,
    output logic                                 done,
    output logic                                 out_valid,
    output logic                                 out_last
);

    localparam int SW  = SYSTOLIC_WIDTH;
    localparam int LAT = LAT_CYCLES(SW);
    localparam logic [ROW_CNT_W-1:0] CNT_ONE  = ROW_CNT_W'(1);
    localparam logic [ROW_CNT_W-1:0] SW_LAST  = ROW_CNT_W'(SW - 1);
    localparam logic [ROW_CNT_W-1:0] LAT_LAST = ROW_CNT_W'(LAT - 1);
`ifdef SYSTOLIC_FEEDER_OS_EN
    localparam logic [ROW_CNT_W-1:0] FLUSH_LAST = ROW_CNT_W'(2 * SW - 2);
`endif

    feeder_state_e        state_q, state_d;
    logic [ROW_CNT_W-1:0] cnt_q, cnt_d;
    logic [ROW_CNT_W-1:0] rows_q;
    logic [ROW_CNT_W-1:0] rows_last;
    logic                 w_acc_q;
    logic                 w_acc, a_acc, stream_acc, job_start;
    logic                 pipe_valid, pipe_last;

    assign job_start  = (state_q == S_IDLE) && start;
    assign rows_last  = rows_q - CNT_ONE;
    assign w_acc      = w_valid && w_ready;
    assign a_acc      = a_valid && a_ready;
    assign stream_acc = a_acc && (state_q == S_STREAM);

    assign a_in_raw   = a_acc ? a_data : '0;
    assign b_in_raw   = w_acc ? w_data : '0;
    assign sum_in_raw = '0;
    assign busy       = (state_q != S_IDLE);
    assign done       = (state_q == S_DONE);

    // OS feed takes a beat only when both streams offer one, so both readies
    // follow the joint valid and never complete a one-sided handshake.
    always_comb begin
        w_ready = 1'b0;
        a_ready = 1'b0;
        case (state_q)
            S_WLOAD:    w_ready = 1'b1;
            S_STREAM:   a_ready = 1'b1;
`ifdef SYSTOLIC_FEEDER_OS_EN
            S_OS_FEED: begin
                w_ready = a_valid && w_valid;
                a_ready = a_valid && w_valid;
            end
`endif
            default: ;
        endcase
    end

    // Load-phase enable mirrors the accept one cycle late, so w_valid gaps freeze the PEs.
    always_comb begin
        enable = 1'b0;
        state  = 1'b0;
        case (state_q)
            S_WLOAD:   enable = w_acc_q;
            S_WSETTLE: enable = 1'b1;
            S_STREAM, S_DRAIN: begin
                enable = 1'b1;
                state  = 1'b1;
            end
`ifdef SYSTOLIC_FEEDER_OS_EN
            S_OS_CLEAR, S_OS_DRAIN: enable = 1'b1;
            S_OS_FEED, S_OS_FLUSH: begin
                enable = 1'b1;
                state  = 1'b1;
            end
`endif
            default: ;
        endcase
    end

    // NOTE: defaults first so every path assigns state_d/cnt_d and no latch is inferred.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    cnt_d   = '0;
`ifdef SYSTOLIC_FEEDER_OS_EN
                    state_d = os_mode ? S_OS_CLEAR : S_WLOAD;
`else
                    state_d = S_WLOAD;
`endif
                end
            end
            S_WLOAD: begin
                if (w_acc) begin
                    if (cnt_q == SW_LAST) begin
                        state_d = S_WSETTLE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
            end
            S_WSETTLE: state_d = (rows_q == '0) ? S_DRAIN : S_STREAM;
            S_STREAM: begin
                if (a_acc) begin
                    if (cnt_q == rows_last) begin
                        state_d = S_DRAIN;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
            end
            S_DRAIN: begin
                if (cnt_q == LAT_LAST) begin
                    state_d = S_DONE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            S_DONE: state_d = S_IDLE;
`ifdef SYSTOLIC_FEEDER_OS_EN
            S_OS_CLEAR: begin
                if (cnt_q == SW_LAST) begin
                    state_d = (rows_q == '0) ? S_OS_FLUSH : S_OS_FEED;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            S_OS_FEED: begin
                if (a_acc) begin
                    if (cnt_q == rows_last) begin
                        state_d = S_OS_FLUSH;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
            end
            S_OS_FLUSH: begin
                if (cnt_q == FLUSH_LAST) begin
                    state_d = S_OS_DRAIN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            S_OS_DRAIN: begin
                if (cnt_q == SW_LAST) begin
                    state_d = S_DONE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
`endif
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            rows_q  <= '0;
            w_acc_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            w_acc_q <= w_acc;
            if (job_start) rows_q <= num_rows;
        end
    end

    valid_pipe #(
        .DEPTH (LAT)
    ) u_valid_pipe (
        .clk     (clk),
        .rst_n   (rst_n),
        .valid_i (stream_acc),
        .last_i  (stream_acc && (cnt_q == rows_last)),
        .valid_o (pipe_valid),
        .last_o  (pipe_last)
    );

`ifdef SYSTOLIC_FEEDER_OS_EN
    logic os_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)         os_q <= 1'b0;
        else if (job_start) os_q <= os_mode;
    end

    // OS results drain straight out of the accumulators, bypassing the row pipe.
    assign mode      = os_q && busy;
    assign out_valid = pipe_valid || (state_q == S_OS_DRAIN);
    assign out_last  = pipe_last || ((state_q == S_OS_DRAIN) && (cnt_q == SW_LAST));
`else
    logic unused_os_mode;

    assign unused_os_mode = os_mode;
    assign mode           = 1'b0;
    assign out_valid      = pipe_valid;
    assign out_last       = pipe_last;
`endif

endmodule
